// File: rtl/trig_seq_controller.sv
// trig_seq_controller
//
// Trigger sequencer. Once armed (EN=1, Mode!=00), a rising edge on Trig_In
// latches the sequence settings. It then runs delay/pulse cycles:
//   single   : one pulse, then Done.
//   burst    : Burst_Cnt pulses (0 counts as 1), then Done.
//   infinite : pulses forever; Pulse_Cnt wraps and Done never fires.
// The first pulse starts D+2 cycles after the edge-sample cycle. Pulses repeat
// with a period of W+D+1 cycles. W=0 is treated as W=1.
//
// Ports
//   Clock      : sole clock, rising edge.
//   Reset      : synchronous, active-high. Clears state, outputs and counters.
//   EN         : sequencer enable; dropping it returns to IDLE.
//   Trig_In    : trigger request (already synchronous).
//   Mode       : 00 off, 01 single, 10 burst, 11 infinite.
//   Delay_Vin  : delay before each pulse, in cycles.
//   Width_Vin  : pulse high time, in cycles.
//   Burst_Cnt  : pulses per burst.
//   Abort      : cancel the active sequence (no Done).
//   Dout       : registered trigger pulse.
//   Busy       : high while in DELAY or PULSE.
//   Done       : one-cycle strobe when a single/burst sequence completes.
//   Pulse_Cnt  : pulses issued in the current sequence.
//
// Build option
//   TRIG_RETRIGGER_EN : when defined, a trigger edge seen in DELAY or PULSE
//                       restarts the sequence with freshly latched settings.
//                       When undefined, such edges are ignored.

module trig_seq_controller #(
  parameter int DELAY_W = 34,
  parameter int CNT_W   = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               EN,
  input  logic               Trig_In,
  input  logic [1:0]         Mode,
  input  logic [DELAY_W-1:0] Delay_Vin,
  input  logic [CNT_W-1:0]   Width_Vin,
  input  logic [CNT_W-1:0]   Burst_Cnt,
  input  logic               Abort,
  output logic               Dout,
  output logic               Busy,
  output logic               Done,
  output logic [CNT_W-1:0]   Pulse_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  state_t state_q, state_d;

  logic               trig_q;
  logic               trig_edge;
  logic               retrig;
  logic               kill;

  logic [1:0]         mode_l;
  logic [DELAY_W-1:0] delay_l;
  logic [CNT_W-1:0]   width_l;
  logic [CNT_W-1:0]   burst_l;

  logic [DELAY_W-1:0] dcnt;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   pcnt;

  logic [CNT_W-1:0]   width_m1;
  logic [CNT_W-1:0]   burst_eff;
  logic               last_pulse;

  // Sequencer actions decided by the next-state logic
  logic load_seq;
  logic reload;
  logic enter_pulse;
  logic seq_done;

  logic dout_d, busy_d, done_d;

  assign trig_edge = Trig_In & ~trig_q;
  assign kill      = Abort | ~EN;

`ifdef TRIG_RETRIGGER_EN
  assign retrig = trig_edge;
`else
  assign retrig = 1'b0;
`endif

  // Width 0 behaves as 1, so the pulse-width counter loads W-1 (floored at 0).
  assign width_m1   = (width_l == '0) ? '0 : width_l - CNT_W'(1);
  assign burst_eff  = (burst_l == '0) ? CNT_W'(1) : burst_l;
  assign last_pulse = (mode_l == MODE_SINGLE) ||
                      ((mode_l == MODE_BURST) && (pcnt == burst_eff));

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= Trig_In;
    end
  end

  // Next-state logic; Abort/EN=0 beats every other condition, including a
  // simultaneous trigger edge.
  always_comb begin
    state_d     = state_q;
    load_seq    = 1'b0;
    reload      = 1'b0;
    enter_pulse = 1'b0;
    seq_done    = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Mode != MODE_OFF) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (Mode == MODE_OFF) begin
            state_d = S_IDLE;
          end else if (trig_edge) begin
            load_seq = 1'b1;
            state_d  = S_DELAY;
          end
        end
        S_DELAY: begin
          if (retrig) begin
            load_seq = 1'b1;
            state_d  = S_DELAY;
          end else if (dcnt == '0) begin
            enter_pulse = 1'b1;
            state_d     = S_PULSE;
          end
        end
        S_PULSE: begin
          if (retrig) begin
            load_seq = 1'b1;
            state_d  = S_DELAY;
          end else if (wcnt == '0) begin
            if (last_pulse) begin
              seq_done = 1'b1;
              state_d  = S_ARMED;
            end else begin
              reload  = 1'b1;
              state_d = S_DELAY;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic (registered below so the outputs track the state exactly)
  always_comb begin
    dout_d = (state_d == S_PULSE);
    busy_d = (state_d == S_DELAY) || (state_d == S_PULSE);
    done_d = seq_done;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Dout <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Dout <= dout_d;
      Busy <= busy_d;
      Done <= done_d;
    end
  end

  // Latched sequence settings and pulse-width counter (pure data)
  always_ff @(posedge Clock) begin
    if (load_seq) begin
      mode_l  <= Mode;
      delay_l <= Delay_Vin;
      width_l <= Width_Vin;
      burst_l <= Burst_Cnt;
    end
    if (enter_pulse) begin
      wcnt <= width_m1;
    end else if ((state_q == S_PULSE) && (wcnt != '0)) begin
      wcnt <= wcnt - CNT_W'(1);
    end
  end

  // Delay and pulse counters; Pulse_Cnt wraps naturally at all-ones.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dcnt <= '0;
      pcnt <= '0;
    end else begin
      if (load_seq) begin
        dcnt <= Delay_Vin;
      end else if (reload) begin
        dcnt <= delay_l;
      end else if ((state_q == S_DELAY) && (dcnt != '0)) begin
        dcnt <= dcnt - DELAY_W'(1);
      end
      if (load_seq) begin
        pcnt <= '0;
      end else if (enter_pulse) begin
        pcnt <= pcnt + CNT_W'(1);
      end
    end
  end

  assign Pulse_Cnt = pcnt;

endmodule

// File: tb/tb_trig_seq_controller.sv
// Testbench for trig_seq_controller. The pulse counter is narrowed to 8 bits
// so that an infinite-mode wrap of Pulse_Cnt fits in a short run.
module tb_trig_seq_controller;

  localparam int DELAY_W = 34;
  localparam int CNT_W   = 8;

  logic               Clock = 1'b0;
  logic               Reset, EN, Trig_In, Abort;
  logic [1:0]         Mode;
  logic [DELAY_W-1:0] Delay_Vin;
  logic [CNT_W-1:0]   Width_Vin, Burst_Cnt;
  logic               Dout, Busy, Done;
  logic [CNT_W-1:0]   Pulse_Cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  trig_seq_controller #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .EN(EN), .Trig_In(Trig_In), .Mode(Mode),
    .Delay_Vin(Delay_Vin), .Width_Vin(Width_Vin), .Burst_Cnt(Burst_Cnt),
    .Abort(Abort), .Dout(Dout), .Busy(Busy), .Done(Done), .Pulse_Cnt(Pulse_Cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, " Dout"}, Dout, 0);
    check({tag, " Busy"}, Busy, 0);
    check({tag, " Done"}, Done, 0);
  endtask

  // ---------------- reference model (closed-form timing) ----------------
  function automatic longint seq_end(input int mode, input longint d, input longint w, input longint b);
    longint we, p, n;
    we = (w == 0) ? 1 : w;
    p  = d + we + 1;
    if (mode == 3) return 64'h3fff_ffff_ffff_ffff;
    n = (mode == 1) ? 1 : ((b == 0) ? 1 : b);
    return d + 2 + (n - 1) * p + we;
  endfunction

  // Expected outputs c cycles after the edge-sample cycle (c >= 1).
  function automatic void model(input int mode, input longint d, input longint w, input longint b,
                                input longint c, output bit e_dout, output bit e_busy,
                                output bit e_done, output longint e_cnt);
    longint we, p, first, n, k, started, endc;
    we    = (w == 0) ? 1 : w;
    p     = d + we + 1;
    first = d + 2;
    n     = (mode == 1) ? 1 : (mode == 2) ? ((b == 0) ? 1 : b) : -1;
    endc  = seq_end(mode, d, w, b);
    if (c < first) begin
      started = 0;
      e_dout  = 0;
    end else begin
      k       = (c - first) / p;
      started = (n < 0 || k + 1 < n) ? k + 1 : n;
      e_dout  = ((c - first) % p) < we && (n < 0 || k < n);
    end
    e_busy = (c >= 1) && (c < endc);
    e_done = (n > 0) && (c == endc);
    e_cnt  = started % (64'd1 << CNT_W);
  endfunction

  // Trig_In low for a cycle, then high with new settings: the second of these
  // cycles is the edge-sample cycle; returns at its negedge.
  task automatic start_seq(input int mode, input longint d, input longint w, input longint b);
    @(posedge Clock); #1;
    Trig_In = 1'b0;
    @(posedge Clock); #1;
    Mode      = mode[1:0];
    Delay_Vin = d[DELAY_W-1:0];
    Width_Vin = w[CNT_W-1:0];
    Burst_Cnt = b[CNT_W-1:0];
    Trig_In   = 1'b1;
    @(negedge Clock);
  endtask

  // Steps cycles c_from..c_to after the edge, scrambling the live settings
  // (they must be ignored once latched) and comparing against the model.
  task automatic check_seq(input int mode, input longint d, input longint w, input longint b,
                           input int c_from, input int c_to, output int first_hi, output int done_at);
    bit ed, eb, edn;
    longint ec, endc;
    first_hi = -1;
    done_at  = -1;
    endc = seq_end(mode, d, w, b);
    for (int c = c_from; c <= c_to; c++) begin
      @(posedge Clock); #1;
`ifdef TRIG_RETRIGGER_EN
      Trig_In = 1'b0;
`else
      Trig_In = (c > 1 && c < endc) ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
      Delay_Vin = {2'($urandom), 32'($urandom)};
      Width_Vin = CNT_W'($urandom);
      Burst_Cnt = CNT_W'($urandom);
      Mode      = (c < endc) ? 2'($urandom) : 2'b01;
      @(negedge Clock);
      model(mode, d, w, b, c, ed, eb, edn, ec);
      check($sformatf("m%0d c%0d Dout", mode, c), Dout, ed);
      check($sformatf("m%0d c%0d Busy", mode, c), Busy, eb);
      check($sformatf("m%0d c%0d Done", mode, c), Done, edn);
      check($sformatf("m%0d c%0d Pulse_Cnt", mode, c), Pulse_Cnt, ec);
      if (Dout === 1'b1 && first_hi < 0) first_hi = c;
      if (Done === 1'b1 && done_at < 0) done_at = c;
    end
  endtask

  typedef struct {
    int     mode;
    longint d, w, b;
    int     first_hi, done_at, cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int fh, da, rm;
    longint rd, rw, rb;

    tbl[0] = '{1, 5, 3, 0, 7, 10, 1};   // single D=5 W=3
    tbl[1] = '{2, 2, 1, 4, 4, 17, 4};   // burst of 4, period 4
    tbl[2] = '{2, 1, 2, 0, 3, 5, 1};    // burst count 0 behaves as 1
    tbl[3] = '{1, 0, 0, 0, 2, 3, 1};    // width 0 behaves as 1
    tbl[4] = '{2, 0, 2, 3, 2, 10, 3};
    tbl[5] = '{1, 3, 0, 7, 5, 6, 1};

    // Reset overrides active inputs
    Reset = 1'b1; EN = 1'b1; Mode = 2'b01; Trig_In = 1'b1; Abort = 1'b0;
    Delay_Vin = '0; Width_Vin = '0; Burst_Cnt = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_idle_outs("reset");
    check("reset Pulse_Cnt", Pulse_Cnt, 0);
    @(posedge Clock); #1;
    Reset = 1'b0; Trig_In = 1'b0;
    @(posedge Clock); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      start_seq(tbl[i].mode, tbl[i].d, tbl[i].w, tbl[i].b);
      check_seq(tbl[i].mode, tbl[i].d, tbl[i].w, tbl[i].b, 1, tbl[i].done_at + 2, fh, da);
      check($sformatf("tbl%0d first_hi", i), fh, tbl[i].first_hi);
      check($sformatf("tbl%0d done_at", i), da, tbl[i].done_at);
      check($sformatf("tbl%0d final Pulse_Cnt", i), Pulse_Cnt, tbl[i].cnt);
    end

    // Randomized single/burst sequences
    for (int i = 0; i < 10; i++) begin
      rm = $urandom_range(1, 2);
      rd = $urandom_range(0, 6);
      rw = $urandom_range(0, 4);
      rb = $urandom_range(0, 5);
      start_seq(rm, rd, rw, rb);
      check_seq(rm, rd, rw, rb, 1, int'(seq_end(rm, rd, rw, rb)) + 2, fh, da);
      check($sformatf("rnd%0d done_at", i), da, seq_end(rm, rd, rw, rb));
    end

    // Infinite D=0 W=0: toggles every cycle, Pulse_Cnt wraps, never Done
    start_seq(3, 0, 0, 0);
    check_seq(3, 0, 0, 0, 1, 2 * (1 << CNT_W) + 8, fh, da);
    check("inf no Done", da, -1);
    @(posedge Clock); #1;
    EN = 1'b0; Trig_In = 1'b0;
    @(posedge Clock); #1;
    EN = 1'b1; Mode = 2'b01;
    @(negedge Clock);
    check_idle_outs("inf EN=0");
    @(posedge Clock); #1;

    // Abort in PULSE of a burst of 3 (D=2 W=3: first pulse cycles 4..6)
    start_seq(2, 2, 3, 3);
    check_seq(2, 2, 3, 3, 1, 5, fh, da);
    @(posedge Clock); #1;
    Abort = 1'b1; Trig_In = 1'b0; Mode = 2'b10;
    @(negedge Clock);
    check("abort still pulsing", Dout, 1);
    @(posedge Clock); #1;
    Abort = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      check_idle_outs($sformatf("after abort %0d", c));
      @(posedge Clock); #1;
    end

    // Abort together with a trigger edge in ARMED: no sequence starts
    Trig_In = 1'b0;
    @(posedge Clock); #1;
    Trig_In = 1'b1; Abort = 1'b1; Delay_Vin = '0; Width_Vin = CNT_W'(1); Mode = 2'b01;
    @(posedge Clock); #1;
    Abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      check_idle_outs($sformatf("abort+trig %0d", c));
      @(posedge Clock); #1;
    end
    Trig_In = 1'b0;
    @(posedge Clock); #1;

    // Reset in DELAY with the maximum delay, then a normal sequence
    start_seq(1, (64'd1 << 34) - 1, 1, 0);
    check_seq(1, (64'd1 << 34) - 1, 1, 0, 1, 4, fh, da);
    @(posedge Clock); #1;
    Reset = 1'b1; Trig_In = 1'b0; Mode = 2'b01;
    @(negedge Clock);
    check("pre-reset Busy", Busy, 1);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check_idle_outs("reset in DELAY");
    check("reset in DELAY Pulse_Cnt", Pulse_Cnt, 0);
    @(posedge Clock); #1;
    start_seq(1, 2, 1, 0);
    check_seq(1, 2, 1, 0, 1, 7, fh, da);
    check("post-reset first_hi", fh, 4);
    check("post-reset done_at", da, 5);

    // Trigger edge in DELAY (burst of 2, D=4): edge 3 cycles in, new D=1
    start_seq(2, 4, 1, 2);
    check_seq(2, 4, 1, 2, 1, 1, fh, da);
    start_seq(1, 1, 2, 0);
`ifdef TRIG_RETRIGGER_EN
    check_seq(1, 1, 2, 0, 1, 7, fh, da);
    check("retrig first_hi", fh, 3);
    check("retrig done_at", da, 5);
`else
    check_seq(2, 4, 1, 2, 4, 15, fh, da);
    check("ignored edge first_hi", fh, 6);
    check("ignored edge done_at", da, 13);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_seq_controller.md
TRIG_SEQ_CONTROLLER -- requirements
Module: trig_seq_controller

Interface
REQ-001 SHALL have parameter DELAY_W, default 34, delay counter width.
REQ-002 SHALL have parameter CNT_W, default 16, burst/pulse counter and pulse-width width.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port EN  input  1  sequencer enable.
REQ-006 SHALL have port Trig_In  input  1  trigger request, already synchronous to Clock.
REQ-007 SHALL have port Mode  input  2  00 off, 01 single, 10 burst, 11 infinite.
REQ-008 SHALL have port Delay_Vin  input  DELAY_W  delay before each pulse, in cycles.
REQ-009 SHALL have port Width_Vin  input  CNT_W  pulse high time, in cycles.
REQ-010 SHALL have port Burst_Cnt  input  CNT_W  pulses per burst.
REQ-011 SHALL have port Abort  input  1  cancel the active sequence.
REQ-012 SHALL have port Dout  output  1  registered trigger pulse.
REQ-013 SHALL have port Busy  output  1  high in DELAY or PULSE.
REQ-014 SHALL have port Done  output  1  one-cycle strobe when a single or burst sequence completes.
REQ-015 SHALL have port Pulse_Cnt  output  CNT_W  number of pulses issued in the current sequence.

Function
REQ-016 SHALL implement the FSM states IDLE, ARMED, DELAY and PULSE.
REQ-017 SHALL treat a trigger edge as Trig_In=1 in the current cycle with a registered Trig_In=0 in the previous cycle.
REQ-018 SHALL move IDLE->ARMED when EN=1 and Mode!=00, and ARMED->IDLE when EN=0 or Mode=00.
REQ-019 SHALL, on a trigger edge in ARMED, latch Mode, Delay_Vin, Width_Vin and Burst_Cnt; load the delay counter; clear Pulse_Cnt; enter DELAY.
REQ-020 SHALL decrement the delay counter in DELAY, and move to PULSE on the cycle after the counter reads 0.
REQ-021 SHALL hold Dout=1 in PULSE for the latched width; a width of 0 SHALL be treated as 1.
REQ-022 SHALL first drive Dout high D+2 cycles after the edge-sample cycle, where D is the latched delay.
REQ-023 SHALL increment Pulse_Cnt on entry to PULSE; in infinite mode it SHALL wrap from all-ones to 0.
REQ-024 SHALL, at the end of PULSE, go to ARMED with Done=1 for one cycle if the mode is single, or if the mode is burst and Pulse_Cnt equals the latched Burst_Cnt (a Burst_Cnt of 0 is treated as 1).
REQ-025 SHALL, at the end of PULSE in all other cases, reload the latched delay and re-enter DELAY; the pulse period is W+D+1 cycles.
REQ-026 SHALL, when Abort=1 or EN=0 in any state, go to IDLE on the next cycle with Dout=0 and no Done; Abort SHALL take priority over a simultaneous trigger edge.
REQ-027 SHALL ignore changes on Mode, Delay_Vin, Width_Vin and Burst_Cnt after they are latched.
REQ-028 SHALL drive Busy=1 exactly in DELAY and PULSE.

Reset
REQ-029 SHALL, while Reset=1, force state=IDLE, Dout=0, Busy=0, Done=0, Pulse_Cnt=0, delay counter=0, and registered Trig_In=0; Reset SHALL override all other inputs, including mid-pulse.

Configuration
REQ-030 SHALL, with macro TRIG_RETRIGGER_EN defined, treat a trigger edge in DELAY or PULSE as a restart: relatch the inputs, clear Pulse_Cnt, enter DELAY, drive Dout low next cycle, and issue no Done.
REQ-031 SHALL, with TRIG_RETRIGGER_EN undefined, ignore trigger edges in DELAY and PULSE.

Verification
REQ-032 SHALL verify single mode: D=5, W=3, edge sampled at cycle t -> Dout high t+7..t+9, Done at t+10, Pulse_Cnt=1, return to ARMED.
REQ-033 SHALL verify burst mode: Burst_Cnt=4, D=2, W=1 -> 4 pulses with period 4 cycles, exactly one Done, Pulse_Cnt=4.
REQ-034 SHALL verify infinite mode: D=0, W=0 -> Dout high 1 of every 2 cycles, Pulse_Cnt wraps from 16'hFFFF to 0, no Done.
REQ-035 SHALL verify Abort during PULSE of a burst of 3 -> Dout=0 and IDLE next cycle, no Done; Abort together with a trigger edge in ARMED -> no pulse.
REQ-036 SHALL verify Reset asserted in DELAY with D=2^34-1 -> all outputs at reset values next cycle; trigger after release -> normal sequence.
REQ-037 SHALL verify an edge in DELAY -> restart with a new Delay_Vin when TRIG_RETRIGGER_EN is defined, and ignored when it is undefined.
